ddr2_cmd_sched: RTL

Single-port command scheduler between a host request interface and the DDR2 DRAM model (x16, 4 banks).
- Runs power-up CKE sequencing.
- Turns each host read/write request into ACTIVATE, READ/WRITE and PRECHARGE commands with NOP spacing.
- Drives DQ/DQS for writes and captures the first read beat.
- Sits between the testbench/host agent and the DRAM pins in the verification top.

---
 rtl/ddr2_cmd_sched_if.sv | 25 ++
 rtl/ddr2_cmd_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_sched_if.sv
// Host request/response bundle for ddr2_cmd_sched.
// The host drives req_* (master); the scheduler answers on req_ready and rsp_* (slave).
interface ddr2_cmd_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_bank;
    logic [12:0] req_row;
    logic [9:0]  req_col;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_bank, req_row, req_col, req_wdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_bank, req_row, req_col, req_wdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ddr2_cmd_sched.sv
// Single-port DDR2 command scheduler: CKE power-up, ACT/RD/WR/PRE sequencing, write DQ/DQS drive.
// Define OPEN_PAGE_EN for an open-page policy; the default build closes the row after every access.
module ddr2_cmd_sched #(
    parameter int unsigned CL          = 7,
    parameter int unsigned T_RCD       = 2,
    parameter int unsigned T_RP        = 2,
    parameter int unsigned INIT_CYCLES = 16
) (
    input  logic            ck,
    input  logic            rst_n,
    ddr2_cmd_sched_if.slave host,
    output logic            cke,
    output logic            cs_n,
    output logic            ras_n,
    output logic            cas_n,
    output logic            we_n,
    output logic [1:0]      ba,
    output logic [12:0]     addr,
    inout  wire  [15:0]     dq,
    inout  wire  [1:0]      dqs,
    inout  wire  [1:0]      dqs_n,
    output logic [1:0]      dm_rdqs,
    output logic            odt
);

    typedef enum logic [3:0] {
        StInit, StCkeWait, StIdle, StAct, StRcdWait, StRd, StRdWait, StWr, StWrWait, StPre, StRpWait
    } state_e;

    localparam int unsigned CntW = 16;
    localparam logic [3:0] CmdNop   = 4'b0111;
    localparam logic [3:0] CmdAct   = 4'b0011;
    localparam logic [3:0] CmdRead  = 4'b0101;
    localparam logic [3:0] CmdWrite = 4'b0100;
    localparam logic [3:0] CmdPre   = 4'b0010;
    localparam logic [12:0] PreAllAddr = 13'h0400;

    localparam logic [CntW-1:0] InitLast = CntW'(INIT_CYCLES);
    localparam logic [CntW-1:0] RcdLast  = CntW'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [CntW-1:0] RpLast   = CntW'((T_RP > 1) ? T_RP - 2 : 0);
    localparam logic [CntW-1:0] RdCap    = CntW'(CL + 1);
    localparam logic [CntW-1:0] RdDone   = CntW'(CL + 4);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              cke_q;
    logic [3:0]        cmd_q;
    logic [1:0]        ba_q;
    logic [12:0]       addr_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [15:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic              oe_q;
    logic [15:0]       dq_q;
    logic [1:0]        dqs_q;
    logic              wr_q;
    logic [1:0]        bank_q;
    logic [9:0]        col_q;
    logic [15:0]       wdata_q;
    logic [15:0]       cap_data_q;
    logic              cap_err_q;
    logic              rw_issue;
    logic              pre_done;
    logic              access_done;
`ifdef OPEN_PAGE_EN
    logic              open_valid_q;
    logic [1:0]        open_bank_q;
    logic [12:0]       open_row_q;
    logic [12:0]       row_q;
`endif

    always_comb begin
        rw_issue    = (state_q == StAct && T_RCD <= 1) || (state_q == StRcdWait && cnt_q == RcdLast);
        pre_done    = (state_q == StPre && T_RP <= 1) || (state_q == StRpWait && cnt_q == RpLast);
        access_done = (state_q == StRdWait && cnt_q == RdDone) ||
                      (state_q == StWrWait && cnt_q == CntW'(1));
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            cke_q       <= 1'b0;
            cmd_q       <= CmdNop;
            ba_q        <= '0;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            oe_q        <= 1'b0;
            dq_q        <= '0;
            dqs_q       <= '0;
            wr_q        <= 1'b0;
            bank_q      <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
`ifdef OPEN_PAGE_EN
            open_valid_q <= 1'b0;
            open_bank_q  <= '0;
            open_row_q   <= '0;
            row_q        <= '0;
`endif
        end else begin
            cmd_q       <= CmdNop;
            rsp_valid_q <= 1'b0;
            cnt_q       <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            unique case (state_q)
                StInit: begin
                    if (cnt_q == InitLast) begin
                        cke_q   <= 1'b1;
                        state_q <= StCkeWait;
                        cnt_q   <= '0;
                    end
                end
                StCkeWait: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (host.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= host.req_write;
                        bank_q      <= host.req_bank;
                        col_q       <= host.req_col;
                        wdata_q     <= host.req_wdata;
`ifdef OPEN_PAGE_EN
                        row_q       <= host.req_row;
                        if (open_valid_q && open_bank_q == host.req_bank &&
                            open_row_q == host.req_row) begin
                            state_q <= host.req_write ? StWr : StRd;
                            cmd_q   <= host.req_write ? CmdWrite : CmdRead;
                            ba_q    <= host.req_bank;
                            addr_q  <= {3'b000, host.req_col};
                        end else if (open_valid_q) begin
                            // Row miss: close the open row, then activate from RP_WAIT.
                            state_q      <= StPre;
                            cmd_q        <= CmdPre;
                            addr_q       <= PreAllAddr;
                            open_valid_q <= 1'b0;
                        end else begin
                            state_q <= StAct;
                            cmd_q   <= CmdAct;
                            ba_q    <= host.req_bank;
                            addr_q  <= host.req_row;
                        end
`else
                        state_q <= StAct;
                        cmd_q   <= CmdAct;
                        ba_q    <= host.req_bank;
                        addr_q  <= host.req_row;
`endif
                    end
                end
                StAct, StRcdWait: begin
                    if (rw_issue) begin
                        state_q <= wr_q ? StWr : StRd;
                        cmd_q   <= wr_q ? CmdWrite : CmdRead;
                        ba_q    <= bank_q;
                        addr_q  <= {3'b000, col_q};
                    end else if (state_q == StAct) begin
                        state_q <= StRcdWait;
                        cnt_q   <= '0;
                    end
                end
                StRd: begin
                    state_q <= StRdWait;
                    cnt_q   <= '0;
                end
                StWr: begin
                    state_q <= StWrWait;
                    cnt_q   <= '0;
                    oe_q    <= 1'b1;
                    dq_q    <= wdata_q;
                    dqs_q   <= 2'b00;
                end
                StRdWait, StWrWait: begin
                    if (state_q == StRdWait && cnt_q == RdCap) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= cap_data_q;
                        rsp_err_q   <= cap_err_q;
                    end
                    if (state_q == StWrWait && cnt_q == '0) begin
                        dqs_q <= 2'b11;
                    end
                    if (state_q == StWrWait && cnt_q == CntW'(1)) begin
                        oe_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                    end
                    if (access_done) begin
`ifdef OPEN_PAGE_EN
                        state_q      <= StIdle;
                        req_ready_q  <= 1'b1;
                        open_valid_q <= 1'b1;
                        open_bank_q  <= bank_q;
                        open_row_q   <= row_q;
`else
                        state_q <= StPre;
                        cmd_q   <= CmdPre;
                        addr_q  <= PreAllAddr;
`endif
                    end
                end
                StPre, StRpWait: begin
                    if (pre_done) begin
`ifdef OPEN_PAGE_EN
                        state_q <= StAct;
                        cmd_q   <= CmdAct;
                        ba_q    <= bank_q;
                        addr_q  <= row_q;
`else
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
`endif
                    end else if (state_q == StPre) begin
                        state_q <= StRpWait;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // First read beat: DRAM drives from rising edge N+CL+1, sampled mid-cycle.
    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cap_data_q <= '0;
            cap_err_q  <= 1'b0;
        end else if (state_q == StRdWait && cnt_q == RdCap) begin
            if (dqs == 2'b11) begin
                cap_data_q <= dq;
                cap_err_q  <= 1'b0;
            end else begin
                cap_data_q <= '0;
                cap_err_q  <= 1'b1;
            end
        end
    end

    assign cke                        = cke_q;
    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign ba                         = ba_q;
    assign addr                       = addr_q;
    assign dq                         = oe_q ? dq_q : 16'hzzzz;
    assign dqs                        = oe_q ? dqs_q : 2'bzz;
    assign dqs_n                      = oe_q ? ~dqs_q : 2'bzz;
    assign dm_rdqs                    = 2'b00;
    assign odt                        = 1'b0;

    assign host.req_ready = req_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_write = rsp_write_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign host.rsp_err   = rsp_err_q;

endmodule
